// File: rtl/hd_program_loader.sv
// -----------------------------------------------------------------------------
// hd_program_loader
//
// Copies a contiguous program image from the HD read port into the
// instruction-memory write port, one word per cycle, before the CPU/BIOS
// starts executing it.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, adds a Checksum output holding the modulo-2^DATA_W sum of
//   every word written during the last accepted transfer.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Start      in   one-cycle request, sampled only in IDLE
//   SrcIndex   in   first HD word address
//   DestBase   in   first instruction-memory word address
//   WordCount  in   number of words to copy
//   HD_Addr    out  HD read address (HD returns data one cycle later)
//   HD_Data    in   HD read data
//   MI_Addr    out  instruction-memory write address
//   MI_Data    out  instruction-memory write data
//   MI_wr      out  instruction-memory write enable
//   Busy       out  high from the cycle after an accepted Start until Done
//   Done       out  one-cycle completion pulse
//   Error      out  sticky range error, cleared by the next accepted Start
//   Checksum   out  (LOADER_CHECKSUM_EN only) sum of written words
//   dbg_state  out  current FSM state (IDLE=0 CHECK=1 STREAM=2 DRAIN=3 FINISH=4)
//
// Handshake: Start is a single-cycle strobe with no ready; it is accepted
// only when the FSM is in IDLE, and ignored in every other state. HD reads
// are fire-and-forget: an address driven in cycle k yields HD_Data in k+1.
// A word is transferred in every cycle where MI_wr is high.
// -----------------------------------------------------------------------------
module hd_program_loader #(
    parameter int DATA_W    = 32,
    parameter int HD_ADDR_W = 16,
    parameter int MI_ADDR_W = 10,
    parameter int CNT_W     = 11
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [HD_ADDR_W-1:0] SrcIndex,
    input  logic [MI_ADDR_W-1:0] DestBase,
    input  logic [CNT_W-1:0]     WordCount,
    output logic [HD_ADDR_W-1:0] HD_Addr,
    input  logic [DATA_W-1:0]    HD_Data,
    output logic [MI_ADDR_W-1:0] MI_Addr,
    output logic [DATA_W-1:0]    MI_Data,
    output logic                 MI_wr,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0]    Checksum,
`endif
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int SUM_W = CNT_W + 1;
    // Memory depth 2^MI_ADDR_W expressed at SUM_W bits so the range check
    // below never wraps.
    localparam logic [SUM_W-1:0] MEM_DEPTH =
        {{(CNT_W - MI_ADDR_W){1'b0}}, 1'b1, {MI_ADDR_W{1'b0}}};

    state_t               state;
    logic [HD_ADDR_W-1:0] src_r;
    logic [MI_ADDR_W-1:0] dest_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     remaining;
    logic [MI_ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0]    data_hold;
    logic [SUM_W-1:0]     range_end;

    assign range_end = SUM_W'(dest_r) + SUM_W'(count_r);
    assign dbg_state = state;

    // HD data arrives in the write cycle itself, so it is passed straight
    // through while MI_wr is high; otherwise the last written word is held.
    assign MI_Data = MI_wr ? HD_Data : data_hold;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            src_r     <= '0;
            dest_r    <= '0;
            count_r   <= '0;
            remaining <= '0;
            wr_ptr    <= '0;
            data_hold <= '0;
            HD_Addr   <= '0;
            MI_Addr   <= '0;
            MI_wr     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            Checksum  <= '0;
`endif
        end else begin
            if (MI_wr) begin
                data_hold <= HD_Data;
            end
`ifdef LOADER_CHECKSUM_EN
            if (MI_wr) begin
                Checksum <= Checksum + HD_Data;
            end
`endif
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        src_r   <= SrcIndex;
                        dest_r  <= DestBase;
                        count_r <= WordCount;
                        Error   <= 1'b0;
                        Busy    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        Checksum <= '0;
`endif
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (count_r == '0) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= FINISH;
                    end else if (range_end > MEM_DEPTH) begin
                        Error <= 1'b1;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        HD_Addr   <= src_r;
                        remaining <= count_r;
                        wr_ptr    <= dest_r;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    // Every read issued here becomes a write next cycle.
                    MI_wr   <= 1'b1;
                    MI_Addr <= wr_ptr;
                    wr_ptr  <= wr_ptr + 1'b1;
                    if (remaining > CNT_W'(1)) begin
                        HD_Addr   <= HD_Addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    MI_wr <= 1'b0;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd_program_loader.sv
// -----------------------------------------------------------------------------
// tb_hd_program_loader
//
// Bench for hd_program_loader: a synchronous-read HD model, a table of load
// requests with expected error/latency, a scoreboard queue of expected
// {address, data} writes with their expected cycles, and hand-written
// sequences for mid-transfer Start and mid-transfer Reset.
// -----------------------------------------------------------------------------
module tb_hd_program_loader;

    localparam int DATA_W    = 32;
    localparam int HD_ADDR_W = 16;
    localparam int MI_ADDR_W = 10;
    localparam int CNT_W     = 11;
    localparam int W         = MI_ADDR_W + DATA_W;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [HD_ADDR_W-1:0] src_index;
    logic [MI_ADDR_W-1:0] dest_base;
    logic [CNT_W-1:0]     word_count;
    logic [HD_ADDR_W-1:0] hd_addr;
    logic [DATA_W-1:0]    hd_data;
    logic [MI_ADDR_W-1:0] mi_addr;
    logic [DATA_W-1:0]    mi_data;
    logic                 mi_wr;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [2:0]           dbg_state;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]    checksum;
`endif

    hd_program_loader #(
        .DATA_W(DATA_W), .HD_ADDR_W(HD_ADDR_W),
        .MI_ADDR_W(MI_ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .Start(start),
        .SrcIndex(src_index),
        .DestBase(dest_base),
        .WordCount(word_count),
        .HD_Addr(hd_addr),
        .HD_Data(hd_data),
        .MI_Addr(mi_addr),
        .MI_Data(mi_data),
        .MI_wr(mi_wr),
        .Busy(busy),
        .Done(done),
        .Error(error),
`ifdef LOADER_CHECKSUM_EN
        .Checksum(checksum),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- HD model: synchronous read ----------------
    logic [DATA_W-1:0] hd_mem [0:65535];
    always @(posedge clk) hd_data <= hd_mem[hd_addr];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mi_wr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got MI_wr=1 addr=%0h data=%0h, expected no write (cycle %0d)",
                         mi_addr, mi_data, cyc);
            end else begin
                logic [W-1:0] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("write_addr", 64'(mi_addr), 64'(e[W-1:DATA_W]));
                check("write_data", 64'(mi_data), 64'(e[DATA_W-1:0]));
                check("write_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [HD_ADDR_W-1:0] src;
        logic [MI_ADDR_W-1:0] dest;
        logic [CNT_W-1:0]     cnt;
        logic                 exp_err;
        int                   exp_lat;  // cycles from Start to Done
        int                   glitch;   // cycle offset of a stray Start (0 = none)
    } vec_t;

    vec_t vecs[13];

    // ---------------- driver ----------------
    task automatic run_load(input vec_t v);
        int                   s;
        int                   t;
        bit                   seen;
        logic [DATA_W-1:0]    sum;
        logic [MI_ADDR_W-1:0] a;
        logic [HD_ADDR_W-1:0] h;
        logic [DATA_W-1:0]    last_data;
        @(negedge clk);
        src_index  = v.src;
        dest_base  = v.dest;
        word_count = v.cnt;
        start      = 1'b1;
        s          = cyc;
        sum        = '0;
        last_data  = '0;
        if (!v.exp_err) begin
            for (int i = 0; i < int'(v.cnt); i++) begin
                a = v.dest + MI_ADDR_W'(i);
                h = v.src + HD_ADDR_W'(i);
                exp_q.push_back({a, hd_mem[h]});
                exp_cyc_q.push_back(s + 3 + i);
                sum       = sum + hd_mem[h];
                last_data = hd_mem[h];
            end
        end
        seen = 1'b0;
        t    = 0;
        while (!seen && t < v.exp_lat + 20) begin
            @(negedge clk);
            t++;
            start = (t == v.glitch);
            if (start) begin
                src_index  = v.src + 16'h0123;
                dest_base  = v.dest ^ 10'h155;
                word_count = 11'd2;
            end
            if (t == 1) check("busy_after_start", 64'(busy), 64'd1);
            if (t == 2 && !v.exp_err && v.cnt != '0)
                check("first_hd_addr", 64'(hd_addr), 64'(v.src));
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("done_latency", 64'(t), 64'(v.exp_lat));
            check("error_at_done", 64'(error), 64'(v.exp_err));
            check("busy_at_done", 64'(busy), 64'd0);
            check("writes_all_seen", 64'(exp_q.size()), 64'd0);
            if (!v.exp_err && v.cnt != '0) begin
                check("mi_addr_hold", 64'(mi_addr), 64'(v.dest + MI_ADDR_W'(v.cnt - 1'b1)));
                check("mi_data_hold", 64'(mi_data), 64'(last_data));
            end
`ifdef LOADER_CHECKSUM_EN
            check("checksum", 64'(checksum), 64'(sum));
`endif
        end
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(dbg_state), 64'd0);
        @(negedge clk);
        check("busy_stays_low", 64'(busy), 64'd0);
        check("error_sticky", 64'(error), 64'(v.exp_err));
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s;
        int done_cnt;
        rst        = 1'b1;
        start      = 1'b0;
        src_index  = '0;
        dest_base  = '0;
        word_count = '0;
        for (int i = 0; i < 65536; i++) hd_mem[i] = $urandom;
        hd_mem[100] = 32'hA;
        hd_mem[101] = 32'hB;
        hd_mem[102] = 32'hC;
        hd_mem[103] = 32'hD;

        //            src       dest      cnt       err lat   glitch
        vecs[0]  = '{16'd100,   10'd0,    11'd4,    1'b0, 7,    0};
        vecs[1]  = '{16'd200,   10'd5,    11'd0,    1'b0, 2,    0};
        vecs[2]  = '{16'd300,   10'd1020, 11'd5,    1'b1, 2,    0};
        vecs[3]  = '{16'd300,   10'd1020, 11'd4,    1'b0, 7,    0};
        vecs[4]  = '{16'hFFFE,  10'd16,   11'd4,    1'b0, 7,    0};
        vecs[5]  = '{16'd400,   10'd50,   11'd6,    1'b0, 9,    4};
        vecs[6]  = '{16'd500,   10'd60,   11'd3,    1'b0, 6,    1};
        vecs[7]  = '{16'd600,   10'd70,   11'd3,    1'b0, 6,    6};
        vecs[8]  = '{16'h1000,  10'd0,    11'd1024, 1'b0, 1027, 0};
        vecs[9]  = '{16'h2000,  10'd1,    11'd1024, 1'b1, 2,    0};
        vecs[10] = '{16'h0010,  10'd0,    11'd2047, 1'b1, 2,    0};
        vecs[11] = '{16'h0020,  10'd1023, 11'd1,    1'b0, 4,    0};
        vecs[12].src    = 16'($urandom);
        vecs[12].dest   = 10'($urandom_range(0, 1023));
        vecs[12].cnt    = 11'($urandom_range(1, 40));
        vecs[12].exp_err = (int'(vecs[12].dest) + int'(vecs[12].cnt)) > 1024;
        vecs[12].exp_lat = vecs[12].exp_err ? 2 : int'(vecs[12].cnt) + 3;
        vecs[12].glitch  = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hd_addr", 64'(hd_addr), 64'd0);
        check("rst_mi_addr", 64'(mi_addr), 64'd0);
        check("rst_mi_data", 64'(mi_data), 64'd0);
        check("rst_mi_wr", 64'(mi_wr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_load(vecs[i]);

        // Reset sampled at the start of the 2nd write cycle of an 8-word load
        @(negedge clk);
        src_index  = 16'h3000;
        dest_base  = 10'd100;
        word_count = 11'd8;
        start      = 1'b1;
        s          = cyc;
        exp_q.push_back({10'd100, hd_mem[16'h3000]});
        exp_cyc_q.push_back(s + 3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;      // first write cycle; sampled at the next edge
        @(negedge clk);
        check("abort_mi_wr", 64'(mi_wr), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hd_addr", 64'(hd_addr), 64'd0);
        check("abort_mi_addr", 64'(mi_addr), 64'd0);
        check("abort_first_write_seen", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        check("abort_checksum_cleared", 64'(checksum), 64'd0);
`endif
        exp_q.delete();
        exp_cyc_q.delete();

        // Normal load after the aborted one
        run_load('{16'h3000, 10'd100, 11'd8, 1'b0, 11, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hd_program_loader.md
Name: hd_program_loader

Overview:
- Copies a contiguous program image from the simulated HD into instruction memory before the CPU or BIOS starts executing it.
- Sits upstream of the instruction memory write port and downstream of the HD read port.
- The BIOS/OS control issues Start with the source HD index, destination base and word count. The loader streams one word per cycle and pulses Done on completion.

Parameters:
- DATA_W, 32, word width of HD and instruction memory.
- HD_ADDR_W, 16, HD word-address width.
- MI_ADDR_W, 10, instruction-memory word-address width; memory depth is 2^MI_ADDR_W.
- CNT_W, 11, width of the word-count input; must be at least MI_ADDR_W+1.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- SrcIndex  in  HD_ADDR_W  first HD word address.
- DestBase  in  MI_ADDR_W  first instruction-memory word address.
- WordCount  in  CNT_W  number of words to copy.
- HD_Addr  out  HD_ADDR_W  HD read address; HD returns data one cycle later.
- HD_Data  in  DATA_W  HD read data.
- MI_Addr  out  MI_ADDR_W  instruction-memory write address.
- MI_Data  out  DATA_W  instruction-memory write data.
- MI_wr  out  1  instruction-memory write enable.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  sticky range error; cleared by the next accepted Start or by Reset.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE
  - HD_Addr = 0, MI_Addr = 0, MI_Data = 0
  - MI_wr = 0, Busy = 0, Done = 0, Error = 0
  - all internal counters = 0
  - Reset mid-transfer aborts immediately. No MI_wr is asserted in the reset cycle or after it, and no Done is issued.
- FSM states: IDLE, CHECK, STREAM, DRAIN, FINISH.
- IDLE:
  - Start=1 latches SrcIndex, DestBase and WordCount, clears Error, and moves to CHECK.
  - Start=0 stays in IDLE.
- CHECK (one cycle, Busy=1):
  - WordCount==0: go to FINISH; no writes.
  - DestBase + WordCount > 2^MI_ADDR_W (sum computed at CNT_W+1 bits, no wrap): set Error=1, go to FINISH; no writes.
  - Otherwise: drive HD_Addr=SrcIndex, remaining=WordCount, go to STREAM.
- STREAM:
  - Each cycle HD_Addr increments by 1 (mod 2^HD_ADDR_W; HD address wrap is allowed) while remaining > 1.
  - Pipeline: the word read at HD_Addr in cycle k is written in cycle k+1 with MI_wr=1, MI_Data=HD_Data, MI_Addr=DestBase+k.
  - After the last read is issued, go to DRAIN.
- DRAIN: write the final word (MI_wr=1), then go to FINISH.
- FINISH: Done=1 for exactly one cycle, Busy=0, return to IDLE.
- Throughput and latency:
  - exactly WordCount consecutive MI_wr cycles, no bubbles;
  - first MI_wr occurs 3 cycles after the Start cycle;
  - Done occurs WordCount+3 cycles after Start.
- Start while not in IDLE is ignored; latched parameters are unaffected.
- Start asserted in the same cycle as Done (FINISH) is ignored; it is accepted only in IDLE.
- MI_wr is never high outside STREAM and DRAIN.
- MI_Addr and MI_Data hold their last values when MI_wr=0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - adds output port Checksum (DATA_W);
  - Checksum is reset to 0 on Reset and on every accepted Start;
  - it accumulates the modulo-2^DATA_W sum of every word written with MI_wr=1;
  - it is valid and stable from the Done cycle until the next accepted Start.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Preload HD[100..103] = 0xA,0xB,0xC,0xD. Start with SrcIndex=100, DestBase=0, WordCount=4 -> MI_wr high 4 consecutive cycles starting 3 cycles after Start, with MI_Addr 0..3 and data 0xA..0xD; Done pulses at Start+7; Checksum=0x2E when LOADER_CHECKSUM_EN is defined.
- WordCount=0 -> no MI_wr; Done at Start+2; Error=0.
- DestBase=1020, WordCount=5 with MI_ADDR_W=10 -> Error=1, no MI_wr, Done at Start+2. Then DestBase=1020, WordCount=4 -> 4 writes to 1020..1023 and Error clears.
- Start pulsed again mid-transfer with different parameters -> ignored; original transfer completes unchanged.
- Reset asserted on the 2nd write cycle of an 8-word load -> MI_wr=0 from that cycle on, Busy=0, no Done. A new Start afterwards completes normally.
- SrcIndex=0xFFFE, WordCount=4 -> HD_Addr sequence FFFE, FFFF, 0000, 0001; four correct writes.
